// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  // Environment side: produces the byte stream, observes memory writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed little-endian byte stream, writes
// 32-bit words into instruction memory, then releases the CPU via cpu_start.
module prog_loader #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  prog_loader_if.slave         bus,
  output logic                 cpu_start,
  output logic                 busy,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] n_q, n_nxt;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_nxt;
  logic [1:0]           byte_idx_q, byte_idx_nxt;
  logic [23:0]          word_q, word_nxt;
  logic                 in_ready_q, in_ready_nxt;
  logic                 im_we_q, im_we_nxt;
  logic [31:0]          im_addr_q, im_addr_nxt;
  logic [31:0]          im_wdata_q, im_wdata_nxt;
  logic                 cpu_start_q, cpu_start_nxt;
  logic                 busy_q, busy_nxt;
  logic                 error_q, error_nxt;
  logic [CNT_WIDTH-1:0] n_full_c;
  logic                 xfer_c;

  assign xfer_c   = bus.in_valid && in_ready_q;
  assign n_full_c = CNT_WIDTH'({bus.in_data, n_q[7:0]});

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_HDR0;
    else      state <= state_nxt;
  end

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_nxt     = state;
    n_nxt         = n_q;
    word_cnt_nxt  = word_cnt_q;
    byte_idx_nxt  = byte_idx_q;
    word_nxt      = word_q;
    im_we_nxt     = 1'b0;
    im_addr_nxt   = im_addr_q;
    im_wdata_nxt  = im_wdata_q;
    in_ready_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    cpu_start_nxt = 1'b0;
    error_nxt     = 1'b0;
    case (state)
      S_HDR0: begin
        if (xfer_c) begin
          n_nxt     = CNT_WIDTH'(bus.in_data);
          state_nxt = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer_c) begin
          n_nxt        = n_full_c;
          byte_idx_nxt = 2'd0;
          word_cnt_nxt = '0;
          if (n_full_c == '0)                      state_nxt = S_DONE;
          else if (32'(n_full_c) > 32'(MAX_WORDS)) state_nxt = S_ERR;
          else                                     state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          byte_idx_nxt = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_nxt[7:0]   = bus.in_data;
            2'd1: word_nxt[15:8]  = bus.in_data;
            2'd2: word_nxt[23:16] = bus.in_data;
            default: begin
              im_wdata_nxt = {bus.in_data, word_q};
              im_addr_nxt  = BASE_ADDR + 32'({word_cnt_q, 2'b00});
              im_we_nxt    = 1'b1;
              state_nxt    = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        word_cnt_nxt = word_cnt_q + CNT_WIDTH'(1);
        if (word_cnt_nxt == n_q) state_nxt = S_DONE;
        else                     state_nxt = S_DATA;
      end
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_HDR0;
    endcase
    in_ready_nxt  = (state_nxt == S_HDR0) || (state_nxt == S_HDR1) || (state_nxt == S_DATA);
    busy_nxt      = (state_nxt == S_HDR1) || (state_nxt == S_DATA) || (state_nxt == S_WRITE);
    cpu_start_nxt = (state_nxt == S_DONE);
    error_nxt     = (state_nxt == S_ERR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q         <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= 2'd0;
      word_q      <= 24'd0;
      in_ready_q  <= 1'b1;
      im_we_q     <= 1'b0;
      im_addr_q   <= 32'd0;
      im_wdata_q  <= 32'd0;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      n_q         <= n_nxt;
      word_cnt_q  <= word_cnt_nxt;
      byte_idx_q  <= byte_idx_nxt;
      word_q      <= word_nxt;
      in_ready_q  <= in_ready_nxt;
      im_we_q     <= im_we_nxt;
      im_addr_q   <= im_addr_nxt;
      im_wdata_q  <= im_wdata_nxt;
      cpu_start_q <= cpu_start_nxt;
      busy_q      <= busy_nxt;
      error_q     <= error_nxt;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wdata  = im_wdata_q;
  assign cpu_start     = cpu_start_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign words_loaded  = word_cnt_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory read path. Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a single-port write interface.
- When loading finishes, raises cpu_start. This signal drives the CPU's active-low start/reset input, so the CPU stays in reset until the whole program is resident.

Parameters:
- MAX_WORDS, 1024, maximum number of program words accepted; must be ≤ 65535.
- CNT_WIDTH, 16, width of the word counter and header field.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  32  instruction-memory byte address, word-aligned.
- im_wdata  output  32  word to write.
- cpu_start  output  1  high when the program is loaded; low holds the CPU in reset.
- busy  output  1  high while in HDR0..WRITE after the first byte is accepted.
- error  output  1  header word count exceeded MAX_WORDS.
- words_loaded  output  CNT_WIDTH  number of words written so far.

Behaviour:
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_data is sampled only on transfer. The sender may drop in_valid at any time and may hold it high across not-ready cycles. A byte that is not transferred is not consumed.
- Stream format:
  - 2 header bytes give N, the word count, low byte first.
  - Then 4*N data bytes, each word low byte first (byte0 → im_wdata[7:0]).
- States:
  - HDR0: in_ready=1. On transfer, store N[7:0] and go to HDR1.
  - HDR1: in_ready=1. On transfer, form N.
    - N==0 → DONE.
    - N>MAX_WORDS → ERR.
    - Otherwise → DATA with byte index 0 and word index 0.
  - DATA: in_ready=1. On transfer, place the byte into the lane given by the 2-bit byte index and increment the index. When the 4th byte transfers → WRITE.
  - WRITE: in_ready=0 and in_valid is ignored. im_we=1 for exactly this one cycle, with:
    - im_addr = BASE_ADDR + 4*word_index, where word_index is the pre-increment value;
    - im_wdata = the assembled word.

    At the end of the cycle, increment word_index and words_loaded. If the new count equals N → DONE, else → DATA.
  - DONE: in_ready=0 and cpu_start=1. Terminal until reset; further bytes are never accepted.
  - ERR: in_ready=0, error=1, cpu_start=0. Terminal until reset.
- Timing:
  - im_we, im_addr and im_wdata are registered. im_we is asserted in the cycle directly after the edge that accepts the 4th byte of a word.
  - cpu_start is registered. It rises on the edge ending the final WRITE cycle. For N==0 it rises on the edge after the 2nd header byte.
  - Peak throughput is 4 bytes per 5 cycles.
- im_addr and im_wdata hold their last values when im_we=0; their contents are don't-care outside WRITE.
- busy is 1 from the first header-byte transfer until DONE or ERR is entered.
- Arithmetic:
  - The address is computed as BASE_ADDR + {word_index, 2'b00}, truncated to 32 bits with no wrap check.
  - N is compared unsigned.
- Reset values (all take effect asynchronously):
  - state=HDR0, in_ready=1 (once out of reset), im_we=0, im_addr=0, im_wdata=0.
  - cpu_start=0, busy=0, error=0, words_loaded=0, byte index=0, word index=0, N=0.
- Reset mid-load: cpu_start and im_we drop immediately without waiting for a clock. Partially assembled bytes are discarded, and words already written stay in memory. After reset release, loading restarts from HDR0.
- A reset asserted in DONE re-holds the CPU in reset; after release a new program is loaded.

Test Plan:
- Two-word load: bytes 02 00 | 13 05 50 00 | 93 05 60 00 streamed back-to-back, BASE_ADDR=0.
  - Expected: im_we pulses with (0x0, 0x00500513) then (0x4, 0x00600593).
  - cpu_start rises one edge after the 2nd write; words_loaded=2; in_ready=0 during each WRITE cycle.
- Empty program: bytes 00 00.
  - Expected: no im_we pulse; cpu_start=1 on the edge after byte 2; busy=0.
- Sender gaps: one-word load with in_valid low for 3 cycles between each byte, held high through the WRITE cycle.
  - Expected: exactly one write of the correct word; no byte is consumed during WRITE.
- Oversize header: MAX_WORDS=4, bytes 05 00.
  - Expected: error=1 and in_ready=0 permanently; cpu_start stays 0; no im_we.
- Reset mid-word: N=1 with 2 data bytes sent, then rst=0 for 1 cycle.
  - Expected: cpu_start and im_we are 0 immediately and all counters clear.
  - Then streaming 01 00 AA BB CC DD gives a write of (0x0, 0xDDCCBBAA) and cpu_start=1.
- Post-done stream: after DONE, hold in_valid=1 for 10 cycles.
  - Expected: in_ready=0 throughout; no im_we; cpu_start stays 1.
